dac_writer: RTL and testbench

Transmit-side counterpart of the ADC scaling path. It accepts one Q1.15 field/drive value per transaction over a valid/ready handshake and converts it to a DAC code with rounding and symmetric saturation. It then drives the code onto the parallel DAC bus with a one-cycle load strobe, waits a programmable settling interval, and reports completion. It sits between the control/weight-programming logic and each phase-shifter/modulator DAC channel, and holds the interface contract "±1.0 ↔ ±2047 LSB" in the opposite direction to the receive path.

---
 rtl/cc_dac_pkg.sv | 27 ++
 rtl/dac_writer_if.sv | 28 ++
 rtl/dac_code_conv.sv | 50 +++++
 rtl/dac_writer.sv | 98 +++++++++
 tb/tb_dac_writer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_dac_pkg.sv
// cc_dac_pkg
//   Shared definitions for the DAC transmit path: writer FSM states,
//   zero-code constants for both output encodings and the Q1.15
//   full-scale limits.
package cc_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DONE
  } dac_state_e;

  // Q1.15 input full-scale limits
  localparam int Q15_FULL_POS = 32767;
  localparam int Q15_FULL_NEG = -32768;

  // Zero code of a 12-bit DAC in each encoding
  localparam logic [11:0] DAC_ZERO_TWOS   = 12'h000;
  localparam logic [11:0] DAC_ZERO_OFFSET = 12'h800;

  // Zero code for any DAC width: offset binary parks at mid-scale
  function automatic int dac_zero_code(input int dac_width, input bit offset_binary);
    return offset_binary ? (2 ** (dac_width - 1)) : 0;
  endfunction

endpackage

// File: rtl/dac_writer_if.sv
// dac_writer_if
//   Bundles the upstream valid/ready sample stream and the DAC-side
//   outputs of one writer channel.
//   master: drives s_valid/s_q15, observes everything else
//   slave : the dac_writer itself
interface dac_writer_if #(
  parameter int Q15_WIDTH = 16,
  parameter int DAC_WIDTH = 12
);
  logic                 s_valid;
  logic                 s_ready;
  logic [Q15_WIDTH-1:0] s_q15;
  logic [DAC_WIDTH-1:0] dac_data;
  logic                 dac_load;
  logic                 busy;
  logic                 settled;
  logic                 clipped;

  modport master (
    output s_valid, s_q15,
    input  s_ready, dac_data, dac_load, busy, settled, clipped
  );

  modport slave (
    input  s_valid, s_q15,
    output s_ready, dac_data, dac_load, busy, settled, clipped
  );
endinterface

// File: rtl/dac_code_conv.sv
// dac_code_conv
//   Purely combinational Q1.15 -> DAC code converter.
//   q15_i  : signed Q1.15 sample
//   code_o : rounded (half up), symmetrically saturated DAC code,
//            MSB inverted when OFFSET_BINARY
//   clip_o : 1 when saturation altered the rounded value
module dac_code_conv #(
  parameter int Q15_WIDTH     = 16,
  parameter int DAC_WIDTH     = 12,
  parameter int OFFSET_BINARY = 1
) (
  input  logic [Q15_WIDTH-1:0] q15_i,
  output logic [DAC_WIDTH-1:0] code_o,
  output logic                 clip_o
);
  localparam int SHIFT = Q15_WIDTH - DAC_WIDTH;
  localparam int EW    = Q15_WIDTH + 1;

  // One extra bit of headroom so +full-scale plus the rounding term cannot wrap
  localparam logic signed [EW-1:0] RND   = EW'((SHIFT > 0) ? (2 ** (SHIFT - 1)) : 0);
  localparam logic signed [EW-1:0] MAX_E = EW'((2 ** (DAC_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] MIN_E = -MAX_E;
  localparam logic [DAC_WIDTH-1:0] MAX_D = DAC_WIDTH'((2 ** (DAC_WIDTH - 1)) - 1);
  localparam logic [DAC_WIDTH-1:0] MIN_D = DAC_WIDTH'(-((2 ** (DAC_WIDTH - 1)) - 1));

  logic signed [EW-1:0]  ext;
  logic signed [EW-1:0]  rnd;
  logic signed [EW-1:0]  shr;
  logic [DAC_WIDTH-1:0]  sat;

  always_comb begin
    ext    = {q15_i[Q15_WIDTH-1], q15_i};
    rnd    = ext + RND;
    shr    = rnd >>> SHIFT;
    sat    = shr[DAC_WIDTH-1:0];
    clip_o = 1'b0;
    // Lower bound is -MAX, not -MAX-1, so the most negative code is never emitted
    if (shr > MAX_E) begin
      sat    = MAX_D;
      clip_o = 1'b1;
    end else if (shr < MIN_E) begin
      sat    = MIN_D;
      clip_o = 1'b1;
    end
    code_o = sat;
    if (OFFSET_BINARY != 0) begin
      code_o[DAC_WIDTH-1] = ~sat[DAC_WIDTH-1];
    end
  end
endmodule

// File: rtl/dac_writer.sv
// dac_writer
//   Accepts one Q1.15 value per handshake, converts it to a DAC code,
//   presents it with a one-cycle load strobe, waits SETTLE_CYCLES and
//   pulses settled (with clipped) before accepting again.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : s_valid/s_ready/s_q15 in, dac_data/dac_load/busy/settled/clipped out
module dac_writer
  import cc_dac_pkg::*;
#(
  parameter int DAC_WIDTH     = 12,
  parameter int Q15_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int OFFSET_BINARY = 1
) (
  input logic         clk,
  input logic         rst,
  dac_writer_if.slave bus
);
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [DAC_WIDTH-1:0] ZERO_CODE =
      DAC_WIDTH'(dac_zero_code(DAC_WIDTH, OFFSET_BINARY != 0));

  dac_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DAC_WIDTH-1:0] dac_data_q;
  logic                 clip_q;
  logic [DAC_WIDTH-1:0] conv_code;
  logic                 conv_clip;
  logic                 accept;

  dac_code_conv #(
    .Q15_WIDTH    (Q15_WIDTH),
    .DAC_WIDTH    (DAC_WIDTH),
    .OFFSET_BINARY(OFFSET_BINARY)
  ) u_conv (
    .q15_i (bus.s_q15),
    .code_o(conv_code),
    .clip_o(conv_clip)
  );

  assign accept = bus.s_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dac_data_q <= ZERO_CODE;
      clip_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Captured on the accept edge so the new code is already on the bus
      // during the LOAD cycle, aligned with dac_load.
      if (accept) begin
        dac_data_q <= conv_code;
        clip_q     <= conv_clip;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (SETTLE_CYCLES > 0) begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SETTLE: begin
        // Counter runs SETTLE_CYCLES-1 .. 0, giving exactly SETTLE_CYCLES cycles
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.s_ready  = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.dac_load = (state_q == ST_LOAD);
  assign bus.settled  = (state_q == ST_DONE);
  assign bus.clipped  = (state_q == ST_DONE) && clip_q;
  assign bus.dac_data = dac_data_q;
endmodule

// File: tb/tb_dac_writer.sv
// tb_dac_writer
//   Three writer instances share clk/rst and the input stream:
//     inst0: SETTLE_CYCLES=16, two's complement
//     inst1: SETTLE_CYCLES=0,  two's complement
//     inst2: SETTLE_CYCLES=0,  offset binary
//   A transaction-timing reference model tracks accepts per instance and
//   predicts every output each cycle.
module tb_dac_writer;
  import cc_dac_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_q15 = 16'h0;

  wire [11:0] dd [N];
  wire        ld [N];
  wire        st [N];
  wire        rd [N];
  wire        bz [N];
  wire        cl [N];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          acc   [N];
  int          avail [N];
  logic [11:0] pcode [N];
  bit          pclip [N];
  logic [11:0] dmodel[N];

  always #5 clk = ~clk;

  function automatic int s_of(input int i);
    return (i == 0) ? 16 : 0;
  endfunction

  function automatic bit ob_of(input int i);
    return (i == 2);
  endfunction

  function automatic logic [11:0] zero_of(input int i);
    return ob_of(i) ? 12'h800 : 12'h000;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g
      dac_writer_if #(.Q15_WIDTH(16), .DAC_WIDTH(12)) intf ();
      assign intf.s_valid = s_valid;
      assign intf.s_q15   = s_q15;
      dac_writer #(
        .DAC_WIDTH    (12),
        .Q15_WIDTH    (16),
        .SETTLE_CYCLES((gi == 0) ? 16 : 0),
        .OFFSET_BINARY((gi == 2) ? 1 : 0)
      ) dut (
        .clk(clk),
        .rst(rst),
        .bus(intf.slave)
      );
      assign dd[gi] = intf.dac_data;
      assign ld[gi] = intf.dac_load;
      assign st[gi] = intf.settled;
      assign rd[gi] = intf.s_ready;
      assign bz[gi] = intf.busy;
      assign cl[gi] = intf.clipped;
    end
  endgenerate

  // value/16 rounded half up (floor of (x+8)/16), clamped to +-2047
  task automatic ref_conv(input logic [15:0] x, input bit ob,
                          output logic [11:0] code, output bit clip);
    int n;
    int v;
    n = int'($signed(x)) + 8;
    if (n >= 0) v = n / 16;
    else        v = -((-n + 15) / 16);
    clip = 1'b0;
    if (v > 2047) begin
      v = 2047; clip = 1'b1;
    end else if (v < -2047) begin
      v = -2047; clip = 1'b1;
    end
    code = v[11:0];
    if (ob) code[11] = ~code[11];
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      acc[i]    = -1000;
      avail[i]  = 0;
      pcode[i]  = 12'h0;
      pclip[i]  = 1'b0;
      dmodel[i] = zero_of(i);
    end
  endtask

  // One clock: drive inputs, advance model at posedge, check all outputs at negedge
  task automatic step(input logic v, input logic [15:0] x);
    bit el, es, er;
    s_valid = v;
    s_q15   = x;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (v && cyc >= avail[i]) begin
        acc[i]   = cyc;
        avail[i] = cyc + s_of(i) + 3;
        ref_conv(x, ob_of(i), pcode[i], pclip[i]);
      end
    end
    cyc++;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      el = (cyc == acc[i] + 1);
      es = (cyc == acc[i] + s_of(i) + 2);
      er = (cyc >= avail[i]);
      if (el) dmodel[i] = pcode[i];
      n_tests += 6;
      if (ld[i] !== el) begin
        n_fail++; $display("FAIL dac_load inst%0d cyc%0d: got %b want %b", i, cyc, ld[i], el);
      end
      if (st[i] !== es) begin
        n_fail++; $display("FAIL settled inst%0d cyc%0d: got %b want %b", i, cyc, st[i], es);
      end
      if (rd[i] !== er) begin
        n_fail++; $display("FAIL s_ready inst%0d cyc%0d: got %b want %b", i, cyc, rd[i], er);
      end
      if (bz[i] !== !er) begin
        n_fail++; $display("FAIL busy inst%0d cyc%0d: got %b want %b", i, cyc, bz[i], !er);
      end
      if (cl[i] !== (es && pclip[i])) begin
        n_fail++; $display("FAIL clipped inst%0d cyc%0d: got %b want %b", i, cyc, cl[i], es && pclip[i]);
      end
      if (dd[i] !== dmodel[i]) begin
        n_fail++; $display("FAIL dac_data inst%0d cyc%0d: got %h want %h", i, cyc, dd[i], dmodel[i]);
      end
    end
  endtask

  // Hold s_valid with x until inst0 accepts; returns the accept edge
  task automatic send0(input logic [15:0] x, output int a);
    int k;
    k = 0;
    a = -1;
    while (a < 0 && k < 40) begin
      step(1'b1, x);
      if (acc[0] == cyc - 1) a = acc[0];
      k++;
    end
    s_valid = 1'b0;
    n_tests++;
    if (a < 0) begin
      n_fail++; $display("FAIL accept_timeout inst0: got no accept want accept within 40 cycles");
    end
  endtask

  task automatic wait_idle();
    int  k;
    bit  idle;
    k = 0;
    idle = 1'b0;
    while (!idle && k < 40) begin
      step(1'b0, 16'h0);
      idle = rd[0] && rd[1] && rd[2];
      k++;
    end
    n_tests++;
    if (!idle) begin
      n_fail++; $display("FAIL idle_timeout: got busy want all idle within 40 cycles");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_tests += 5;
      if (dd[i] !== zero_of(i)) begin
        n_fail++; $display("FAIL reset_data inst%0d: got %h want %h", i, dd[i], zero_of(i));
      end
      if (rd[i] !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready inst%0d: got %b want 1", i, rd[i]);
      end
      if (ld[i] !== 1'b0 || st[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_strobes inst%0d: got load=%b settled=%b want 0 0", i, ld[i], st[i]);
      end
      if (bz[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy inst%0d: got %b want 0", i, bz[i]);
      end
      if (cl[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_clipped inst%0d: got %b want 0", i, cl[i]);
      end
    end
    rst = 1'b0;
    cyc = 0;
    model_reset();
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0);
    $display("[TB] reset: zero codes %h %h %h", dd[0], dd[1], dd[2]);
  endtask

  task automatic test_full_scale();
    int a, load_c, set_c, nload;
    logic [11:0] code_at_load;
    bit clip_at_set;
    load_c = -1; set_c = -1; nload = 0;
    code_at_load = 12'h0; clip_at_set = 1'b0;
    send0(Q15_FULL_POS[15:0], a);
    if (ld[0]) begin load_c = cyc; code_at_load = dd[0]; nload++; end
    for (int k = 0; k < 24; k++) begin
      step(1'b0, 16'h0);
      if (ld[0]) begin load_c = cyc; code_at_load = dd[0]; nload++; end
      if (st[0] && set_c < 0) begin set_c = cyc; clip_at_set = cl[0]; end
    end
    n_tests += 5;
    if (load_c - a !== 1) begin
      n_fail++; $display("FAIL fs_load_latency: got %0d want 1", load_c - a);
    end
    if (set_c - a !== 18) begin
      n_fail++; $display("FAIL fs_settle_latency: got %0d want 18", set_c - a);
    end
    if (code_at_load !== 12'h7FF) begin
      n_fail++; $display("FAIL fs_code: got %h want 7ff", code_at_load);
    end
    if (clip_at_set !== 1'b1) begin
      n_fail++; $display("FAIL fs_clipped: got %b want 1", clip_at_set);
    end
    if (nload !== 1) begin
      n_fail++; $display("FAIL fs_load_count: got %0d want 1", nload);
    end
    $display("[TB] full scale: load +%0d settled +%0d code %h", load_c - a, set_c - a, code_at_load);
  endtask

  task automatic test_codes();
    logic [15:0] vin  [3] = '{16'h8000, 16'h0008, 16'h0007};
    logic [11:0] vexp [3] = '{12'h801, 12'h001, 12'h000};
    bit          cexp [3] = '{1'b1, 1'b0, 1'b0};
    int a;
    bit clip_seen;
    for (int t = 0; t < 3; t++) begin
      clip_seen = 1'b0;
      send0(vin[t], a);
      for (int k = 0; k < 20; k++) begin
        step(1'b0, 16'h0);
        if (st[0]) clip_seen = cl[0];
      end
      n_tests += 2;
      if (dd[0] !== vexp[t]) begin
        n_fail++; $display("FAIL code_%h: got %h want %h", vin[t], dd[0], vexp[t]);
      end
      if (clip_seen !== cexp[t]) begin
        n_fail++; $display("FAIL clip_%h: got %b want %b", vin[t], clip_seen, cexp[t]);
      end
      $display("[TB] convert %h -> %h clipped=%b", vin[t], dd[0], clip_seen);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] x;
    int          nacc, k;
    int          lc [2];
    logic [11:0] lcode [2];
    int          nl;
    x = 16'h1000; nacc = 0; k = 0; nl = 0;
    lc[0] = 0; lc[1] = 0; lcode[0] = 12'h0; lcode[1] = 12'h0;
    while (nl < 2 && k < 20) begin
      step(1'b1, x);
      if (ld[1]) begin lc[nl] = cyc; lcode[nl] = dd[1]; nl++; end
      if (acc[1] == cyc - 1) begin nacc++; if (nacc == 1) x = 16'hF000; end
      k++;
    end
    s_valid = 1'b0;
    n_tests += 3;
    if (lcode[0] !== 12'h100) begin
      n_fail++; $display("FAIL b2b_code0: got %h want 100", lcode[0]);
    end
    if (lcode[1] !== 12'hF00) begin
      n_fail++; $display("FAIL b2b_code1: got %h want f00", lcode[1]);
    end
    if (lc[1] - lc[0] !== 3) begin
      n_fail++; $display("FAIL b2b_period: got %0d want 3", lc[1] - lc[0]);
    end
    $display("[TB] back-to-back: codes %h %h period %0d", lcode[0], lcode[1], lc[1] - lc[0]);
    wait_idle();
  endtask

  task automatic test_ignore_in_settle();
    int a, nload;
    logic [15:0] x;
    logic [11:0] ecode;
    bit eclip;
    x = 16'($urandom_range(0, 16'h7FFF));
    ref_conv(x, 1'b0, ecode, eclip);
    send0(x, a);
    nload = ld[0] ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0);
      if (ld[0]) nload++;
    end
    step(1'b1, ~x);
    if (ld[0]) nload++;
    for (int k = 0; k < 18; k++) begin
      step(1'b0, 16'h0);
      if (ld[0]) nload++;
    end
    n_tests += 2;
    if (nload !== 1) begin
      n_fail++; $display("FAIL ignore_load_count: got %0d want 1", nload);
    end
    if (dd[0] !== ecode) begin
      n_fail++; $display("FAIL ignore_data: got %h want %h", dd[0], ecode);
    end
    $display("[TB] ignore in settle: x=%h code %h loads %0d", x, dd[0], nload);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int a, nset;
    nset = 0;
    send0(16'h4000, a);
    for (int k = 0; k < 3; k++) step(1'b0, 16'h0);
    rst = 1'b1;
    #1;
    n_tests += 4;
    if (dd[0] !== 12'h000) begin
      n_fail++; $display("FAIL rstmid_data: got %h want 000", dd[0]);
    end
    if (bz[0] !== 1'b0 || rd[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_state: got busy=%b ready=%b want 0 1", bz[0], rd[0]);
    end
    if (st[0] !== 1'b0 || ld[0] !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_strobes: got load=%b settled=%b want 0 0", ld[0], st[0]);
    end
    if (dd[2] !== 12'h800) begin
      n_fail++; $display("FAIL rstmid_data_ob: got %h want 800", dd[2]);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 16'h0);
      if (st[0]) nset++;
    end
    n_tests++;
    if (nset !== 0) begin
      n_fail++; $display("FAIL rstmid_settled: got %0d pulses want 0", nset);
    end
    send0(16'h0008, a);
    step(1'b0, 16'h0);
    n_tests++;
    if (dd[0] !== 12'h001) begin
      n_fail++; $display("FAIL rstmid_next: got %h want 001", dd[0]);
    end
    $display("[TB] reset mid-settle: recovered code %h", dd[0]);
    wait_idle();
  endtask

  task automatic test_random();
    int a, sel;
    logic [15:0] x;
    for (int t = 0; t < 30; t++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: x = Q15_FULL_POS[15:0];
        1: x = Q15_FULL_NEG[15:0];
        2: x = 16'($signed(int'($urandom_range(0, 32)) - 16));
        default: x = 16'($urandom);
      endcase
      send0(x, a);
      for (int k = 0; k < int'($urandom_range(0, 22)); k++) begin
        step(1'($urandom_range(0, 1)), 16'($urandom));
      end
      s_valid = 1'b0;
      $display("[TB] random txn %0d: x=%h inst0 code %h", t, x, dd[0]);
    end
    wait_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_scale();
    test_codes();
    test_back_to_back();
    test_ignore_in_settle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish before 2ms");
    $fatal(1, "timeout");
  end
endmodule
